// File: rtl/risc8_pkg.sv
// Shared risc8 types and constants used by the COM instruction sequencer.
package risc8_pkg;

  localparam int word_size = 8;

  typedef enum logic [1:0] {
    CP_RAM  = 2'd0,
    CP_ROM  = 2'd1,
    CP_FPU  = 2'd2,
    CP_GPIO = 2'd3
  } e_cp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } e_com_state;

  // Read word returned when a co-processor never acknowledges.
  localparam logic [7:0] COM_ERR_DATA = 8'hFF;

endpackage

// File: rtl/risc8_com_ctrl.sv
// COM instruction sequencer: req/ack handshake with one co-processor, core stall,
// response write-back and timeout protection against an unresponsive co-processor.
module risc8_com_ctrl
  import risc8_pkg::*;
#(
  parameter int WORD     = 8,
  parameter int CP_COUNT = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_cp,
  input  logic                     cmd_wr,
  input  logic [WORD-1:0]          cmd_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic [WORD-1:0]          rsp_data,
  output logic                     rsp_err,
  output logic [CP_COUNT-1:0]      cp_req,
  output logic                     cp_wr,
  output logic [WORD-1:0]          cp_wdata,
  input  logic [CP_COUNT-1:0]      cp_ack,
  input  logic [CP_COUNT*WORD-1:0] cp_rdata
);

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  e_com_state          state_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          sel_q;
  logic [CP_COUNT-1:0] cp_req_q;
  logic                cp_wr_q;
  logic [WORD-1:0]     cp_wdata_q;
  logic                rsp_valid_q;
  logic [WORD-1:0]     rsp_data_q;
  logic                rsp_err_q;

  logic [WORD-1:0]     rdata_sel;
  logic                ack_sel;

  assign rdata_sel = cp_rdata[sel_q*WORD +: WORD];
  assign ack_sel   = cp_ack[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      cp_req_q    <= '0;
      cp_wr_q     <= 1'b0;
      cp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cmd_valid) begin
            sel_q      <= cmd_cp;
            cp_req_q   <= CP_COUNT'(1) << cmd_cp;
            cp_wr_q    <= cmd_wr;
            cp_wdata_q <= cmd_wdata;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          // Ack wins over a coincident timeout so real data is never discarded.
          if (ack_sel) begin
            rsp_data_q  <= cp_wr_q ? cp_wdata_q : rdata_sel;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            cp_req_q    <= '0;
            cp_wr_q     <= 1'b0;
            state_q     <= RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            rsp_data_q  <= WORD'(COM_ERR_DATA);
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            cp_req_q    <= '0;
            cp_wr_q     <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Low in RESP so the instruction retires in the same cycle rsp_data is valid.
  assign stall = ((state_q == IDLE) && cmd_valid) || (state_q == REQ);

  assign cp_req    = cp_req_q;
  assign cp_wr     = cp_wr_q;
  assign cp_wdata  = cp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_risc8_com_ctrl.sv
// Bench for risc8_com_ctrl: transaction-level predictor (ack delay -> response
// cycle, data, error) checked cycle by cycle against the DUT.
module tb_risc8_com_ctrl;

  localparam int WORD = 8;
  localparam int CPN  = 4;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic [1:0]      cmd_cp;
  logic            cmd_wr;
  logic [WORD-1:0] cmd_wdata;
  logic            stall;
  logic            rsp_valid;
  logic [WORD-1:0] rsp_data;
  logic            rsp_err;
  logic [CPN-1:0]  cp_req;
  logic            cp_wr;
  logic [WORD-1:0] cp_wdata;
  logic [CPN-1:0]  cp_ack;
  logic [CPN*WORD-1:0] cp_rdata;

  int checks   = 0;
  int failures = 0;
  logic [WORD-1:0] last_data = '0;
  logic            last_err  = 1'b0;

  risc8_com_ctrl #(.WORD(WORD), .CP_COUNT(CPN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_cp(cmd_cp), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cp_req(cp_req), .cp_wr(cp_wr), .cp_wdata(cp_wdata),
    .cp_ack(cp_ack), .cp_rdata(cp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // One COM access. d = cycle (relative to cmd_valid) at which the selected
  // co-processor acks; d outside 1..TO means it never acks -> timeout.
  task automatic run_txn(input int cp, input bit wr, input logic [7:0] wd,
                         input int d, input bit noise, input bit hold_next);
    bit acks = (d >= 1 && d <= TO);
    int last = acks ? d : TO;
    logic [7:0] exp_data = 8'hFF;
    logic [CPN-1:0] sel_bit = CPN'(1) << cp;
    logic [CPN*WORD-1:0] rd;
    for (int t = 0; t <= last + 1; t++) begin
      @(negedge clk);
      cmd_valid = (t <= last) ? 1'b1 : hold_next;
      cmd_cp    = 2'(cp);
      cmd_wr    = wr;
      cmd_wdata = wd;
      rd        = $urandom;
      cp_rdata  = rd;
      cp_ack    = noise ? (CPN'($urandom) & ~sel_bit) : '0;
      if (acks && t == d) begin
        cp_ack   = cp_ack | sel_bit;
        exp_data = wr ? wd : rd[cp*WORD +: WORD];
      end
      #1;
      if (t == 0) begin
        chk("idle_stall", stall, 1);
        chk("idle_req", cp_req, 0);
        chk("idle_rsp_valid", rsp_valid, 0);
      end else if (t <= last) begin
        chk("req_stall", stall, 1);
        chk("req_onehot", cp_req, sel_bit);
        chk("req_wr", cp_wr, wr);
        chk("req_wdata", cp_wdata, wd);
        chk("req_rsp_valid", rsp_valid, 0);
      end else begin
        chk("resp_stall", stall, 0);
        chk("resp_req", cp_req, 0);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_err", rsp_err, !acks);
        chk("resp_data", rsp_data, exp_data);
        last_data = exp_data;
        last_err  = !acks;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cp_ack    = CPN'($urandom);
      cp_rdata  = $urandom;
      #1;
      chk("gap_stall", stall, 0);
      chk("gap_req", cp_req, 0);
      chk("gap_rsp_valid", rsp_valid, 0);
      chk("gap_hold_data", rsp_data, last_data);
      chk("gap_hold_err", rsp_err, last_err);
    end
  endtask

  initial begin
    int cp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_cp = '0; cmd_wr = 1'b0;
    cmd_wdata = '0; cp_ack = '0; cp_rdata = '0;
    #23;
    chk("rst_req", cp_req, 0);
    chk("rst_wr", cp_wr, 0);
    chk("rst_wdata", cp_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(2);

    run_txn(1, 1'b0, 8'h00, 1, 1'b0, 1'b0);   // fast read
    idle_cycles(1);
    run_txn(3, 1'b1, 8'hC3, 6, 1'b0, 1'b0);   // slow write
    idle_cycles(1);
    run_txn(0, 1'b0, 8'h00, 5, 1'b1, 1'b0);   // wrong-port acks ignored
    idle_cycles(1);
    run_txn(2, 1'b0, 8'h00, 99, 1'b1, 1'b0);  // timeout
    idle_cycles(1);
    run_txn(2, 1'b0, 8'h00, TO, 1'b0, 1'b0);  // ack coincides with timeout
    idle_cycles(1);
    run_txn(1, 1'b0, 8'h00, 2, 1'b0, 1'b1);   // back-to-back
    run_txn(3, 1'b0, 8'h00, 1, 1'b0, 1'b0);
    idle_cycles(1);

    // Reset mid-REQ drops the access with no response.
    @(negedge clk); cmd_valid = 1'b1; cmd_cp = 2'd2; cmd_wr = 1'b0; cp_ack = '0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("midreq_req", cp_req, 4'b0100);
    rst_n = 1'b0; cmd_valid = 1'b0; #1;
    chk("midreq_rst_req", cp_req, 0);
    chk("midreq_rst_stall", stall, 0);
    chk("midreq_rst_data", rsp_data, 0);
    last_data = '0; last_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(20);

    for (int n = 0; n < 40; n++) begin
      cp = int'($urandom_range(0, 3));
      run_txn(cp, 1'($urandom), 8'($urandom), int'($urandom_range(1, 20)),
              1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
